// File: rtl/sp_mem_arb.sv
// Two-port round-robin arbiter in front of a single-port SRAM wrapper.
// After reset it can zero-fill the whole SRAM before it starts accepting requests.
module sp_mem_arb #(
    parameter int DW        = 32,
    parameter int AW        = 10,
    parameter int INIT_ZERO = 1
) (
    input  logic            clk,
    input  logic            rst_i,
    input  logic            p0_req_i,
    output logic            p0_gnt_o,
    input  logic [AW-1:0]   p0_addr_i,
    input  logic            p0_we_i,
    input  logic [DW/8-1:0] p0_be_i,
    input  logic [DW-1:0]   p0_wdata_i,
    output logic            p0_rvalid_o,
    output logic [DW-1:0]   p0_rdata_o,
    input  logic            p1_req_i,
    output logic            p1_gnt_o,
    input  logic [AW-1:0]   p1_addr_i,
    input  logic            p1_we_i,
    input  logic [DW/8-1:0] p1_be_i,
    input  logic [DW-1:0]   p1_wdata_i,
    output logic            p1_rvalid_o,
    output logic [DW-1:0]   p1_rdata_o,
    output logic            mem_en_o,
    output logic            mem_we_o,
    output logic [AW-1:0]   mem_addr_o,
    output logic [DW/8-1:0] mem_be_o,
    output logic [DW-1:0]   mem_wdata_o,
    input  logic [DW-1:0]   mem_rdata_i,
    output logic            init_done_o
);
    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;
    localparam logic [0:0] ST_RST  = (INIT_ZERO != 0) ? ST_INIT : ST_RUN;

    logic [0:0]    r_state;
    logic [AW-1:0] r_cnt;
    logic          r_rr;
    logic          r_rv0, r_rv1, r_rd0, r_rd1;

    logic w_run, w_init, w_g0, w_g1, w_last;

    // Everything that can touch the SRAM is gated by reset so nothing is enabled while it is held.
    assign w_run  = (r_state == ST_RUN)  && !rst_i;
    assign w_init = (r_state == ST_INIT) && !rst_i;
    assign w_g0   = w_run && p0_req_i && (!p1_req_i || !r_rr);
    assign w_g1   = w_run && p1_req_i && !w_g0;
    assign w_last = (r_cnt == {AW{1'b1}});

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            r_state <= ST_RST;
            r_cnt   <= '0;
            r_rr    <= 1'b0;
            r_rv0   <= 1'b0;
            r_rv1   <= 1'b0;
            r_rd0   <= 1'b0;
            r_rd1   <= 1'b0;
        end else begin
            // The counter parks on the last address rather than wrapping.
            if (r_state == ST_INIT) begin
                if (w_last) r_state <= ST_RUN;
                else        r_cnt   <= r_cnt + 1'b1;
            end
            if (w_g0)      r_rr <= 1'b1;
            else if (w_g1) r_rr <= 1'b0;
            r_rv0 <= w_g0;
            r_rv1 <= w_g1;
            r_rd0 <= w_g0 && !p0_we_i;
            r_rd1 <= w_g1 && !p1_we_i;
        end
    end

    always_comb begin
        mem_en_o    = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_be_o    = '0;
        mem_wdata_o = '0;
        if (w_init) begin
            mem_en_o   = 1'b1;
            mem_we_o   = 1'b1;
            mem_addr_o = r_cnt;
            mem_be_o   = '1;
        end else if (w_g0) begin
            mem_en_o    = 1'b1;
            mem_we_o    = p0_we_i;
            mem_addr_o  = p0_addr_i;
            mem_be_o    = p0_be_i;
            mem_wdata_o = p0_wdata_i;
        end else if (w_g1) begin
            mem_en_o    = 1'b1;
            mem_we_o    = p1_we_i;
            mem_addr_o  = p1_addr_i;
            mem_be_o    = p1_be_i;
            mem_wdata_o = p1_wdata_i;
        end
    end

    assign p0_gnt_o    = w_g0;
    assign p1_gnt_o    = w_g1;
    assign p0_rvalid_o = r_rv0;
    assign p1_rvalid_o = r_rv1;
    assign p0_rdata_o  = (r_rv0 && r_rd0) ? mem_rdata_i : '0;
    assign p1_rdata_o  = (r_rv1 && r_rd1) ? mem_rdata_i : '0;
    assign init_done_o = (r_state == ST_RUN);
endmodule

// File: tb/tb_sp_mem_arb.sv
// Bench for sp_mem_arb: behavioural SRAM, cycle-level reference model of the
// arbitration rules, directed scenarios followed by random traffic.
module tb_sp_mem_arb;
    localparam int DW = 32;
    localparam int AW = 4;
    localparam int BW = DW / 8;
    localparam int DEPTH = 1 << AW;

    logic clk = 1'b0;
    logic rst_i = 1'b1;
    logic p0_req_i = 0, p0_we_i = 0, p1_req_i = 0, p1_we_i = 0;
    logic [AW-1:0] p0_addr_i = '0, p1_addr_i = '0;
    logic [BW-1:0] p0_be_i = '0, p1_be_i = '0;
    logic [DW-1:0] p0_wdata_i = '0, p1_wdata_i = '0;
    logic p0_gnt_o, p1_gnt_o, p0_rvalid_o, p1_rvalid_o;
    logic [DW-1:0] p0_rdata_o, p1_rdata_o;
    logic mem_en_o, mem_we_o, init_done_o;
    logic [AW-1:0] mem_addr_o;
    logic [BW-1:0] mem_be_o;
    logic [DW-1:0] mem_wdata_o;
    logic [DW-1:0] mem_rdata_i = '0;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    sp_mem_arb #(.DW(DW), .AW(AW), .INIT_ZERO(1)) dut (
        .clk(clk), .rst_i(rst_i),
        .p0_req_i(p0_req_i), .p0_gnt_o(p0_gnt_o), .p0_addr_i(p0_addr_i), .p0_we_i(p0_we_i),
        .p0_be_i(p0_be_i), .p0_wdata_i(p0_wdata_i), .p0_rvalid_o(p0_rvalid_o), .p0_rdata_o(p0_rdata_o),
        .p1_req_i(p1_req_i), .p1_gnt_o(p1_gnt_o), .p1_addr_i(p1_addr_i), .p1_we_i(p1_we_i),
        .p1_be_i(p1_be_i), .p1_wdata_i(p1_wdata_i), .p1_rvalid_o(p1_rvalid_o), .p1_rdata_o(p1_rdata_o),
        .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_be_o(mem_be_o),
        .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .init_done_o(init_done_o)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // SRAM wrapper: byte-enabled write, registered read. Starts with garbage.
    logic [DW-1:0] sram [DEPTH];
    initial for (int i = 0; i < DEPTH; i++) sram[i] = $urandom;
    always @(posedge clk) begin
        if (mem_en_o) begin
            if (mem_we_o) begin
                for (int b = 0; b < BW; b++)
                    if (mem_be_o[b]) sram[mem_addr_o][8*b +: 8] <= mem_wdata_o[8*b +: 8];
            end else begin
                mem_rdata_i <= sram[mem_addr_o];
            end
        end
    end

    // Reference model: what the SRAM should hold, how many fill cycles have elapsed,
    // whose turn it is on a tie, and the response owed to each port next cycle.
    logic [DW-1:0] sh [DEPTH];
    int            m_icnt = 0;
    bit            m_done = 0;
    int            m_turn = 0;
    bit            m_rv [2];
    bit            m_rd [2];
    logic [DW-1:0] m_dat [2];
    initial for (int i = 0; i < DEPTH; i++) sh[i] = '0;

    always @(negedge clk) begin
        bit            req [2];
        bit            we [2];
        logic [AW-1:0] ad [2];
        logic [BW-1:0] be [2];
        logic [DW-1:0] wd [2];
        int            win;
        req[0] = p0_req_i; we[0] = p0_we_i; ad[0] = p0_addr_i; be[0] = p0_be_i; wd[0] = p0_wdata_i;
        req[1] = p1_req_i; we[1] = p1_we_i; ad[1] = p1_addr_i; be[1] = p1_be_i; wd[1] = p1_wdata_i;
        if (rst_i) begin
            chk("rst_en", mem_en_o, 0);
            chk("rst_rv0", p0_rvalid_o, 0);
            chk("rst_rv1", p1_rvalid_o, 0);
            chk("rst_gnt", {p0_gnt_o, p1_gnt_o}, 0);
            chk("rst_done", init_done_o, 0);
            m_icnt = 0; m_done = 0; m_turn = 0;
            m_rv[0] = 0; m_rv[1] = 0; m_rd[0] = 0; m_rd[1] = 0;
            for (int i = 0; i < DEPTH; i++) sh[i] = '0;
        end else begin
            chk("rv0", p0_rvalid_o, m_rv[0]);
            chk("rv1", p1_rvalid_o, m_rv[1]);
            chk("rdata0", p0_rdata_o, (m_rv[0] && m_rd[0]) ? m_dat[0] : 0);
            chk("rdata1", p1_rdata_o, (m_rv[1] && m_rd[1]) ? m_dat[1] : 0);
            m_rv[0] = 0; m_rv[1] = 0; m_rd[0] = 0; m_rd[1] = 0;
            chk("done", init_done_o, m_done);
            if (!m_done) begin
                chk("init_en", {mem_en_o, mem_we_o}, 2'b11);
                chk("init_addr", mem_addr_o, m_icnt);
                chk("init_be_wd", {mem_be_o, mem_wdata_o}, {{BW{1'b1}}, {DW{1'b0}}});
                chk("init_gnt", {p0_gnt_o, p1_gnt_o}, 0);
                m_icnt++;
                if (m_icnt == DEPTH) m_done = 1;
            end else begin
                if (req[0] && req[1]) win = m_turn;
                else if (req[0])      win = 0;
                else if (req[1])      win = 1;
                else                  win = -1;
                chk("gnt", {p0_gnt_o, p1_gnt_o}, {win == 0, win == 1});
                if (win < 0) begin
                    chk("idle_mem", {mem_en_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o}, 0);
                end else begin
                    chk("mem_ctl", {mem_en_o, mem_we_o, mem_addr_o, mem_be_o},
                        {1'b1, we[win], ad[win], be[win]});
                    chk("mem_wd", mem_wdata_o, wd[win]);
                    m_rv[win]  = 1;
                    m_rd[win]  = !we[win];
                    m_dat[win] = sh[ad[win]];
                    if (we[win])
                        for (int b = 0; b < BW; b++)
                            if (be[win][b]) sh[ad[win]][8*b +: 8] = wd[win][8*b +: 8];
                    m_turn = 1 - win;
                end
            end
        end
    end

    task automatic set_port(input int p, input bit req, input bit we, input logic [AW-1:0] a,
                            input logic [BW-1:0] be, input logic [DW-1:0] wd);
        if (p == 0) begin
            p0_req_i = req; p0_we_i = we; p0_addr_i = a; p0_be_i = be; p0_wdata_i = wd;
        end else begin
            p1_req_i = req; p1_we_i = we; p1_addr_i = a; p1_be_i = be; p1_wdata_i = wd;
        end
    endtask

    // Single access on one port: hold the request until granted, then drop it.
    task automatic access(input int p, input bit we, input logic [AW-1:0] a,
                          input logic [BW-1:0] be, input logic [DW-1:0] wd, input logic [DW-1:0] exp_rd);
        bit got;
        got = 0;
        set_port(p, 1, we, a, be, wd);
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            got = (p == 0) ? p0_gnt_o : p1_gnt_o;
        end
        chk("access_gnt", got, 1);
        @(posedge clk); #1;
        set_port(p, 0, 0, '0, '0, '0);
        @(negedge clk);
        chk("access_rv", (p == 0) ? p0_rvalid_o : p1_rvalid_o, 1);
        if (!we) chk("access_rd", (p == 0) ? p0_rdata_o : p1_rdata_o, exp_rd);
    endtask

    task automatic wait_done();
        int k;
        k = 0;
        while (!init_done_o && k < 4 * DEPTH) begin
            @(negedge clk);
            k++;
        end
        chk("init_timeout", init_done_o, 1);
    endtask

    initial begin
        int seen;
        // p1 holds a read request through reset and the whole fill.
        set_port(1, 1, 0, 4'd5, 4'hF, '0);
        repeat (3) @(posedge clk);
        #1 rst_i = 0;
        wait_done();
        chk("first_run_gnt1", p1_gnt_o, 1);
        @(posedge clk); #1 set_port(1, 0, 0, '0, '0, '0);

        access(0, 1, 4'd3, 4'hF, 32'hDEADBEEF, '0);
        access(0, 0, 4'd3, 4'h0, '0, 32'hDEADBEEF);
        access(1, 1, 4'd7, 4'b0101, 32'hAABBCCDD, '0);
        access(1, 0, 4'd7, 4'h0, '0, 32'h00BB00DD);
        access(0, 0, 4'd9, 4'h0, '0, 32'h0);

        // Both ports contend for six cycles; the model enforces alternation.
        @(posedge clk); #1;
        set_port(0, 1, 0, 4'd3, 4'hF, '0);
        set_port(1, 1, 0, 4'd7, 4'hF, '0);
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (p0_gnt_o) seen++;
        end
        chk("alt_p0_count", seen, 3);
        @(posedge clk); #1;
        set_port(0, 0, 0, '0, '0, '0);
        set_port(1, 0, 0, '0, '0, '0);

        repeat (400) begin
            @(posedge clk); #1;
            set_port(0, ($urandom % 3) != 0, $urandom, $urandom, $urandom, $urandom);
            set_port(1, ($urandom % 3) != 0, $urandom, $urandom, $urandom, $urandom);
        end

        // Reset lands in the cycle carrying a response; that response must vanish.
        set_port(0, 1, 0, 4'd1, 4'hF, '0);
        seen = 0;
        for (int k = 0; k < 10 && !seen; k++) begin
            @(negedge clk);
            seen = p0_gnt_o;
        end
        chk("pre_rst_gnt", seen, 1);
        @(posedge clk); #1 rst_i = 1;
        set_port(0, 0, 0, '0, '0, '0);
        set_port(1, 0, 0, '0, '0, '0);
        @(negedge clk);
        chk("rst_drop_rv", {p0_rvalid_o, p1_rvalid_o}, 0);
        @(posedge clk); #1 rst_i = 0;
        @(negedge clk);
        chk("restart_addr0", {mem_en_o, mem_addr_o}, {1'b1, 4'd0});
        wait_done();
        repeat (60) begin
            @(posedge clk); #1;
            set_port(0, $urandom, $urandom, $urandom, $urandom, $urandom);
            set_port(1, $urandom, $urandom, $urandom, $urandom, $urandom);
        end
        @(posedge clk); #1;
        set_port(0, 0, 0, '0, '0, '0);
        set_port(1, 0, 0, '0, '0, '0);
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/sp_mem_arb.md
SP_MEM_ARB -- requirements
Module: sp_mem_arb

Interface
REQ-001 The module SHALL have the following parameters, one per line: name, default, meaning.
  DW         32  data width; SHALL be a multiple of 8
  AW         10  word address width
  INIT_ZERO  1   1 = zero-fill the whole SRAM after reset; 0 = start in RUN
REQ-002 The module SHALL have the following ports, one per line: name, direction, width, meaning.
  clk           in   1      single clock; all state updates on its rising edge
  rst_i         in   1      asynchronous, active-high reset
  pN_req_i      in   1      requester N access request (N = 0, 1)
  pN_gnt_o      out  1      requester N request accepted this cycle
  pN_addr_i     in   AW     requester N word address
  pN_we_i       in   1      requester N write enable (1 = write, 0 = read)
  pN_be_i       in   DW/8   requester N byte enables
  pN_wdata_i    in   DW     requester N write data
  pN_rvalid_o   out  1      response for requester N; one cycle after pN_gnt_o
  pN_rdata_o    out  DW     read data for requester N, qualified by pN_rvalid_o
  mem_en_o      out  1      SRAM wrapper enable (en_i)
  mem_we_o      out  1      SRAM wrapper write enable (we_i)
  mem_addr_o    out  AW     SRAM wrapper address
  mem_be_o      out  DW/8   SRAM wrapper byte enables
  mem_wdata_o   out  DW     SRAM wrapper write data
  mem_rdata_i   in   DW     SRAM wrapper read data (ram_rdata_o); valid one cycle after a read enable
  init_done_o   out  1      1 = zero-fill complete, arbiter in RUN

Function
REQ-003 The controller SHALL implement a two-state FSM: INIT and RUN.
REQ-004 INIT: each cycle, mem_en_o=1, mem_we_o=1, mem_be_o=all ones, mem_wdata_o=0, mem_addr_o=init counter; the counter increments by 1 per cycle.
REQ-005 INIT SHALL last exactly 2**AW cycles; after the cycle that writes address 2**AW-1, the FSM SHALL go to RUN and set init_done_o=1 on the next edge; the counter SHALL NOT wrap back to 0 within INIT.
REQ-006 In INIT, p0_gnt_o and p1_gnt_o SHALL be 0; requests held through INIT SHALL be eligible for grant in the first RUN cycle.
REQ-007 In RUN, the grant decision SHALL be combinational in the same cycle: only one port requesting -> that port granted; both requesting -> the port selected by the round-robin pointer rr is granted.
REQ-008 The rr pointer SHALL point to the port not granted after every grant; it SHALL be unchanged in cycles with no grant.
REQ-009 In RUN, mem_en_o SHALL equal p0_gnt_o|p1_gnt_o; mem_we_o, mem_addr_o, mem_be_o and mem_wdata_o SHALL come from the granted port; with no grant, mem_we_o=0 and the other mem outputs SHALL be 0.
REQ-010 At most one gnt SHALL be high in any cycle.
REQ-011 pN_rvalid_o SHALL be 1 in exactly the cycle after pN_gnt_o=1, for both reads and writes, even if pN_req_i is deasserted in that cycle.
REQ-012 pN_rdata_o SHALL equal mem_rdata_i while pN_rvalid_o=1 after a read, and 0 otherwise (including write responses).
REQ-013 Back-to-back grants SHALL be possible every cycle; throughput SHALL be one access per cycle; read latency SHALL be 1 cycle from grant.
REQ-014 With INIT_ZERO=0, the FSM SHALL leave reset directly in RUN with init_done_o=1.

Reset
REQ-015 While rst_i=1, regardless of clk: FSM=INIT (or RUN if INIT_ZERO=0), init counter=0, rr=port 0, rvalid registers=0, init_done_o=INIT_ZERO?0:1.
REQ-016 rst_i asserted mid-operation SHALL drop any pending rvalid immediately, with no response delivered; on release, INIT SHALL restart at address 0.
REQ-017 While rst_i=1, the arbiter SHALL NOT drive mem_en_o high.

Verification
REQ-018 AW=4, INIT_ZERO=1, release reset -> mem_en_o=mem_we_o=1 for exactly 16 cycles with addr 0..15, wdata 0; init_done_o rises on cycle 17; every later read returns 0.
REQ-019 After init: p0 writes 0xDEADBEEF, be=4'b1111, to addr 3; p0 then reads addr 3 -> p0_rvalid_o one cycle after each gnt; read returns 0xDEADBEEF.
REQ-020 p0 and p1 both hold req for 6 cycles -> grants alternate 0,1,0,1,0,1; rvalid follows each grant by one cycle on the matching port.
REQ-021 Byte-enable partial write: 0xAABBCCDD with be=4'b0101 to a zeroed address -> read returns 0x00BB00DD.
REQ-022 Assert rst_i in the cycle after a grant -> no rvalid on any port; init restarts from address 0.
REQ-023 p1 holds req during INIT -> p1_gnt_o=0 throughout; granted in the first cycle init_done_o=1.
